// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage controller: writeback-select
// encodings, FSM state type and the default access timeout.
package mem_pkg;

  localparam logic [1:0] WD_SEL_ALU  = 2'b00;
  localparam logic [1:0] WD_SEL_DRAM = 2'b01;
  localparam logic [1:0] WD_SEL_WD   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mem_state_t;

  localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory bus between the memory-stage controller (master) and data
// memory (slave).
//
// Handshake: the master raises dram_req_o and holds it, together with
// dram_we_o / dram_addr_o / dram_wdata_o, stable until the slave answers with
// a single-cycle dram_ack_i. For loads dram_rdata_i is valid only in the ack
// cycle. An ack seen while no request is outstanding is ignored.
interface mem_stage_ctrl_if;
  import mem_pkg::*;

  logic        dram_req_o;
  logic        dram_we_o;
  logic [31:0] dram_addr_o;
  logic [31:0] dram_wdata_o;
  logic        dram_ack_i;
  logic [31:0] dram_rdata_i;

  modport master (
    output dram_req_o,
    output dram_we_o,
    output dram_addr_o,
    output dram_wdata_o,
    input  dram_ack_i,
    input  dram_rdata_i
  );

  modport slave (
    input  dram_req_o,
    input  dram_we_o,
    input  dram_addr_o,
    input  dram_wdata_o,
    output dram_ack_i,
    output dram_rdata_i
  );

endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A bubble loads an all-zero entry so the
// writeback stage never sees a half-finished memory access.
module mem_wb_reg
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bubble,
  input  logic        rf_we_d,
  input  logic [4:0]  wR_d,
  input  logic [31:0] wD_d,
  output logic        rf_we_o,
  output logic [4:0]  wR_o,
  output logic [31:0] wD_o
);

  // Capture the writeback triple every edge, or a zero bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_o <= 1'b0;
      wR_o    <= 5'd0;
      wD_o    <= 32'd0;
    end else if (bubble) begin
      rf_we_o <= 1'b0;
      wR_o    <= 5'd0;
      wD_o    <= 32'd0;
    end else begin
      rf_we_o <= rf_we_d;
      wR_o    <= wR_d;
      wD_o    <= wD_d;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues loads/stores to data memory over the
// req/ack bus, stalls the upstream pipeline while an access is in flight and
// owns the MEM/WB register.
// Optional feature: define MEM_TIMEOUT_EN to abort an access after TIMEOUT
// cycles in REQ with no ack (sets the sticky err_o). Without it REQ waits
// indefinitely and err_o is tied low.
module mem_stage_ctrl
  import mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  wd_sel_i,
  input  logic        rf_we_i,
  input  logic        dram_we_i,
  input  logic [4:0]  wR_i,
  input  logic [31:0] wD_i,
  input  logic [31:0] aluc_i,
  input  logic [31:0] rd2_i,
  output logic        stall_o,
  output logic        rf_we_o,
  output logic [4:0]  wR_o,
  output logic [31:0] wD_o,
  output logic        err_o,
  output mem_state_t  state_o,
  mem_stage_ctrl_if.master dram
);

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("mem_stage_ctrl: TIMEOUT must be at least 1");
  end

  mem_state_t  state_q;
  mem_state_t  state_d;
  logic        mem_op;
  logic        tmo_hit;
  logic        bubble;
  logic        rf_we_d;
  logic [31:0] wb_data;
  logic [31:0] rdata_q;

  assign mem_op  = dram_we_i | (wd_sel_i == WD_SEL_DRAM);
  assign state_o = state_q;

  // EX/MEM is frozen during an access, so the bus fields can come straight
  // from the stage inputs and stay stable while the request is up.
  assign dram.dram_we_o    = dram_we_i;
  assign dram.dram_addr_o  = aluc_i;
  assign dram.dram_wdata_o = rd2_i;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] tmo_cnt_q;
  logic             err_q;

  // Expiry on the last allowed REQ cycle; a simultaneous ack takes priority.
  assign tmo_hit = (state_q == ST_REQ) & ~dram.dram_ack_i &
                   (tmo_cnt_q == CNT_W'(TIMEOUT - 1));
  assign err_o   = err_q;

  // Count REQ cycles; clear whenever REQ is left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else if ((state_q == ST_REQ) && (state_d == ST_REQ)) begin
      tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
    end else begin
      tmo_cnt_q <= '0;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (tmo_hit) begin
      err_q <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err_o   = 1'b0;
`endif

  // Load data is held from the ack cycle until the DONE writeback; an
  // aborted access returns zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 32'd0;
    end else if ((state_q == ST_REQ) && dram.dram_ack_i) begin
      rdata_q <= dram.dram_rdata_i;
    end else if (tmo_hit) begin
      rdata_q <= 32'd0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: IDLE -> REQ on a memory op, REQ -> DONE on ack or
  // expiry, DONE lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mem_op) state_d = ST_REQ;
      ST_REQ:  if (dram.dram_ack_i || tmo_hit) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs. Stall is gated by rst_n so it drops together with the
  // request when reset hits mid-access; EX/MEM advances at the end of DONE.
  always_comb begin
    dram.dram_req_o = (state_q == ST_REQ);
    stall_o         = rst_n & mem_op & (state_q != ST_DONE);
    bubble          = (state_q == ST_REQ) | ((state_q == ST_IDLE) & mem_op);
  end

  // Writeback value select and write enable; a store never writes the
  // register file.
  always_comb begin
    case (wd_sel_i)
      WD_SEL_ALU:  wb_data = aluc_i;
      WD_SEL_DRAM: wb_data = rdata_q;
      default:     wb_data = wD_i;
    endcase
    rf_we_d = (state_q == ST_DONE) ? (rf_we_i & ~dram_we_i) : rf_we_i;
  end

  mem_wb_reg u_mem_wb_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .bubble  (bubble),
    .rf_we_d (rf_we_d),
    .wR_d    (wR_i),
    .wD_d    (wb_data),
    .rf_we_o (rf_we_o),
    .wR_o    (wR_o),
    .wD_o    (wD_o)
  );

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller for the five-stage pipeline. It sits directly downstream of the EX/MEM pipeline register and issues loads and stores to data memory over a req/ack handshake. While an access is in flight it stalls the upstream pipeline. It also contains the MEM/WB pipeline register, so the writeback stage receives a registered `rf_we`/`wR`/`wD` triple.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum number of cycles spent in REQ before an access is aborted. Used only when `MEM_TIMEOUT_EN` is defined.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wd_sel_i`  in  2  writeback select from EX/MEM: 00 ALU result, 01 DRAM read data, 10 `wD_i` passthrough, 11 treated as 10.
- `rf_we_i`  in  1  register-file write enable from EX/MEM.
- `dram_we_i`  in  1  store request from EX/MEM.
- `wR_i`  in  5  destination register.
- `wD_i`  in  32  precomputed writeback value (e.g. PC+4 or immediate).
- `aluc_i`  in  32  ALU result; also the memory address.
- `rd2_i`  in  32  store data.
- `stall_o`  out  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM while high.
- `dram_req_o`  out  1  memory request.
- `dram_we_o`  out  1  1 = store, 0 = load; valid while `dram_req_o` is high.
- `dram_addr_o`  out  32  access address (`aluc_i`).
- `dram_wdata_o`  out  32  store data (`rd2_i`).
- `dram_ack_i`  in  1  memory completion; one cycle wide.
- `dram_rdata_i`  in  32  load data; valid in the cycle `dram_ack_i` is high.
- `rf_we_o`  out  1  MEM/WB register-file write enable.
- `wR_o`  out  5  MEM/WB destination register.
- `wD_o`  out  32  MEM/WB writeback data.
- `err_o`  out  1  sticky timeout flag.

## Operation
- Memory op condition: `mem_op = dram_we_i | (wd_sel_i == 01)`.
- States:
  - IDLE: if `mem_op`, go to REQ; otherwise stay in IDLE.
  - REQ: `dram_req_o` = 1. On `dram_ack_i`: capture `dram_rdata_i` into `rdata_q` and go to DONE.
  - DONE: one cycle, then go to IDLE.
- `stall_o = mem_op & (state != DONE)`. EX/MEM therefore advances at the end of the DONE cycle.
- `dram_addr_o`, `dram_wdata_o` and `dram_we_o` are driven from the `_i` inputs. EX/MEM is frozen during the access, so they stay stable while `dram_req_o` is high.
- `dram_ack_i` is ignored outside REQ.
- MEM/WB update, every edge:
  - Non-mem op in IDLE: `rf_we_o` ← `rf_we_i`, `wR_o` ← `wR_i`, `wD_o` ← select(`aluc_i`, `wD_i`).
  - Mem op in IDLE or REQ: bubble, with `rf_we_o` ← 0 and `wR_o`/`wD_o` ← 0.
  - DONE: `rf_we_o` ← `rf_we_i & ~dram_we_i`, `wR_o` ← `wR_i`, `wD_o` ← `rdata_q` when `wd_sel` = 01.
- Addresses are word accesses only; no alignment checking.

## Timing
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - `rdata_q` is 0 and the timeout counter is 0.
- Reset mid-access: `dram_req_o` drops immediately (asynchronously). The access is abandoned and no writeback occurs.
- Non-mem op: one-cycle latency into MEM/WB; no stall.
- Mem op:
  - Occupancy is 3 cycles when ack arrives in the first REQ cycle, otherwise 2 + (REQ cycles).
  - `stall_o` is high for every occupancy cycle except DONE.
- Back-to-back mem ops: IDLE follows DONE, so the second request starts 1 cycle after DONE. There is no overlap.
- Ack arriving in the same edge as a timeout expiry: the ack wins and `err_o` is not set.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A counter runs while in REQ and clears on leaving REQ.
  - After `TIMEOUT` REQ cycles with no ack: go to DONE with `rdata_q` = 0, and set `err_o` (sticky until reset).
- `MEM_TIMEOUT_EN` undefined: REQ waits indefinitely. No counter is built and `err_o` is tied to 0.

## Structure
- Shared package `mem_pkg`:
  - `wd_sel` encodings (`WD_SEL_ALU`/`DRAM`/`WD`).
  - FSM state typedef (IDLE/REQ/DONE).
  - `TIMEOUT` default.
- One sub-module, `mem_wb_reg`: the MEM/WB register with bubble insert. The FSM, stall logic and writeback mux stay in `mem_stage_ctrl`.

## Test plan
- ALU op (`wd_sel` 00, `aluc` 0x1234, `rf_we` 1, `wR` 5):
  - Required: `stall_o` stays 0.
  - Required: next cycle `rf_we_o` = 1, `wR_o` = 5, `wD_o` = 0x1234.
- Load (`aluc` 0x100) with ack after 2 REQ cycles and rdata 0xDEADBEEF:
  - Required: `dram_req_o` is high for 2 cycles and `stall_o` for 3 cycles.
  - Required: `wD_o` = 0xDEADBEEF one cycle after DONE.
- Store (`aluc` 0x200, `rd2` 0xCAFE) with immediate ack:
  - Required: `dram_we_o` = 1 and `dram_wdata_o` = 0xCAFE while req is high.
  - Required: `rf_we_o` stays 0.
- Two back-to-back loads:
  - Required: two distinct req pulses with at least 1 idle cycle between them, and two writebacks in order.
- `rst_n` pulsed low while in REQ:
  - Required: `dram_req_o`, `stall_o` and `rf_we_o` go to 0 immediately and the state is IDLE after release.
- With `MEM_TIMEOUT_EN` and `TIMEOUT` = 4, load with no ack:
  - Required: `dram_req_o` high for exactly 4 cycles, then `err_o` = 1 and `wD_o` = 0.
